// File: rtl/latch_q_monitor.sv
// Monitors the complementary Q/Qn pair of a gated D-latch. It emits rise/fall pulses, counts rising edges and latches a fault when Q/Qn stay non-complementary.
// Latency: an input edge shows up as a pulse in the cycle after clock edge n+SYNC_STAGES, where n is the first edge that samples the new input level.
// Backpressure: none. Inputs are sampled every cycle. The pulses are single-cycle and cannot be stalled.
module latch_q_monitor #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8,
  parameter int FAULT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             qn_in,
  input  logic             clr_cnt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             tracking,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // The invalid-run counter is 4 bits wide because FAULT_CYCLES is at most 15.
  localparam logic [3:0]       FAULT_LIM = 4'(FAULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_q_sync;
  logic [SYNC_STAGES-1:0] r_qn_sync;
  logic                   w_q_s;
  logic                   w_qn_s;
  logic                   w_valid;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_q_prev;
  logic                   w_q_prev_nxt;
  logic [3:0]             r_inv_cnt;
  logic [3:0]             w_inv_cnt_nxt;
  logic [3:0]             w_inv_inc;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic [CNT_W-1:0]       r_edge_cnt;

  // Synchronise both latch outputs into clk.
  // The reset values form a valid pair (Q=0, Qn=1), so INIT can exit right away.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_sync  <= '0;
      r_qn_sync <= '1;
    end else begin
      r_q_sync  <= {r_q_sync[SYNC_STAGES-2:0], q_in};
      r_qn_sync <= {r_qn_sync[SYNC_STAGES-2:0], qn_in};
    end
  end

  assign w_q_s     = r_q_sync[SYNC_STAGES-1];
  assign w_qn_s    = r_qn_sync[SYNC_STAGES-1];
  assign w_valid   = (w_q_s != w_qn_s);
  assign w_inv_inc = r_inv_cnt + 4'd1;

  // State register, reference value, invalid-run counter and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_q_prev  <= 1'b0;
      r_inv_cnt <= 4'd0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_q_prev  <= w_q_prev_nxt;
      r_inv_cnt <= w_inv_cnt_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
    end
  end

  // Next-state logic. Invalid pairs in TRACK hold the reference and suppress pulses.
  // This filters short Q==Qn overlaps.
  always_comb begin
    w_state_nxt   = r_state;
    w_q_prev_nxt  = r_q_prev;
    w_inv_cnt_nxt = r_inv_cnt;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    case (r_state)
      ST_INIT: begin
        // Adopt the current level silently; the first accepted edge comes later.
        if (w_valid) begin
          w_q_prev_nxt = w_q_s;
          w_state_nxt  = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (w_valid) begin
          w_inv_cnt_nxt = 4'd0;
          if (w_q_s != r_q_prev) begin
            w_rise_nxt   = w_q_s;
            w_fall_nxt   = ~w_q_s;
            w_q_prev_nxt = w_q_s;
          end
        end else begin
          w_inv_cnt_nxt = w_inv_inc;
          if (w_inv_inc == FAULT_LIM) begin
            w_state_nxt = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        // Recovery needs an explicit request while the pair looks healthy again.
        if (clr_cnt && w_valid) begin
          w_state_nxt   = ST_INIT;
          w_inv_cnt_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt   = ST_INIT;
        w_inv_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Saturating rising-edge counter.
  // clr_cnt wins over a simultaneous increment; the pulse itself still fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_edge_cnt <= '0;
    end else if (clr_cnt) begin
      r_edge_cnt <= '0;
    end else if (w_rise_nxt && (r_edge_cnt != CNT_MAX)) begin
      r_edge_cnt <= r_edge_cnt + CNT_ONE;
    end
  end

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign edge_count = r_edge_cnt;
  assign tracking   = (r_state == ST_TRACK);
  assign fault      = (r_state == ST_FAULT);

endmodule

// File: tb/tb_latch_q_monitor.sv
// Bench for latch_q_monitor. It runs a constant vector table, directed sequences and random stimulus.
// Two instances (CNT_W=8 and CNT_W=3) share the same inputs; a queue-based reference model checks every cycle.
// Inputs change 1ns after each rising edge; outputs are sampled at the same point.
module tb_latch_q_monitor;
  localparam int SYNC = 2;
  localparam int FC   = 3;

  logic       clk = 1'b0;
  logic       reset, q_in, qn_in, clr_cnt;
  logic       rise8, fall8, trk8, flt8;
  logic [7:0] cnt8;
  logic       rise3, fall3, trk3, flt3;
  logic [2:0] cnt3;

  always #5 clk = ~clk;

  latch_q_monitor #(.SYNC_STAGES(SYNC), .CNT_W(8), .FAULT_CYCLES(FC)) u_dut8 (
    .clk(clk), .reset(reset), .q_in(q_in), .qn_in(qn_in), .clr_cnt(clr_cnt),
    .rise_pulse(rise8), .fall_pulse(fall8), .edge_count(cnt8),
    .tracking(trk8), .fault(flt8));

  latch_q_monitor #(.SYNC_STAGES(SYNC), .CNT_W(3), .FAULT_CYCLES(FC)) u_dut3 (
    .clk(clk), .reset(reset), .q_in(q_in), .qn_in(qn_in), .clr_cnt(clr_cnt),
    .rise_pulse(rise3), .fall_pulse(fall3), .edge_count(cnt3),
    .tracking(trk3), .fault(flt3));

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Delay lines hold the last SYNC input samples; the oldest entry is the synchronised value.
  bit m_qh[$];
  bit m_qnh[$];
  int m_mode;      // 0 = waiting for a valid pair, 1 = tracking, 2 = faulted
  bit m_ref;
  int m_bad;
  bit m_rise, m_fall;
  int m_cnt8, m_cnt3;

  function automatic void model_edge(input bit r, input bit q, input bit qn, input bit c);
    bit qs, qns, ok;
    if (r) begin
      m_qh.delete();
      m_qnh.delete();
      for (int k = 0; k < SYNC; k++) begin
        m_qh.push_back(1'b0);
        m_qnh.push_back(1'b1);
      end
      m_mode = 0; m_ref = 0; m_bad = 0;
      m_rise = 0; m_fall = 0; m_cnt8 = 0; m_cnt3 = 0;
    end else begin
      qs  = m_qh[SYNC-1];
      qns = m_qnh[SYNC-1];
      ok  = (qs != qns);
      m_rise = 0;
      m_fall = 0;
      if (m_mode == 0) begin
        if (ok) begin m_ref = qs; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (ok) begin
          m_bad = 0;
          if (qs != m_ref) begin
            m_rise = qs;
            m_fall = !qs;
            m_ref  = qs;
          end
        end else begin
          m_bad++;
          if (m_bad == FC) m_mode = 2;
        end
      end else begin
        if (c && ok) begin m_mode = 0; m_bad = 0; end
      end
      if (c) begin
        m_cnt8 = 0; m_cnt3 = 0;
      end else if (m_rise) begin
        m_cnt8 = (m_cnt8 >= 255) ? 255 : m_cnt8 + 1;
        m_cnt3 = (m_cnt3 >= 7) ? 7 : m_cnt3 + 1;
      end
      m_qh.push_front(q);   m_qh.pop_back();
      m_qnh.push_front(qn); m_qnh.pop_back();
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  int obs_rise, obs_fall, wide_err;
  bit prev_rise, prev_fall;

  task automatic step(input logic r, input logic q, input logic qn, input logic c);
    reset = r; q_in = q; qn_in = qn; clr_cnt = c;
    @(posedge clk);
    model_edge(r, q, qn, c);
    #1;
    chk("model_rise8", rise8, m_rise);
    chk("model_fall8", fall8, m_fall);
    chk("model_trk8",  trk8,  m_mode == 1);
    chk("model_flt8",  flt8,  m_mode == 2);
    chk("model_cnt8",  cnt8,  m_cnt8);
    chk("model_cnt3",  cnt3,  m_cnt3);
    chk("model_dut3_flags", {rise3, fall3, trk3, flt3},
        {m_rise, m_fall, m_mode == 1, m_mode == 2});
    if (rise8) obs_rise++;
    if (fall8) obs_fall++;
    if ((rise8 && prev_rise) || (fall8 && prev_fall)) wide_err++;
    prev_rise = rise8;
    prev_fall = fall8;
  endtask

  task automatic hold(input logic q, input logic qn, input logic c, input int n);
    for (int k = 0; k < n; k++) step(1'b0, q, qn, c);
  endtask

  task automatic clear_obs();
    obs_rise = 0; obs_fall = 0; wide_err = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, q, qn, clr;
    logic rise, fall, trk, flt;
    int   cnt;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic rst, input logic q, input logic qn, input logic clr,
                              input logic rise, input logic fall, input logic trk,
                              input logic flt, input int cnt);
    vec_t v;
    v.rst = rst; v.q = q; v.qn = qn; v.clr = clr;
    v.rise = rise; v.fall = fall; v.trk = trk; v.flt = flt; v.cnt = cnt;
    vq.push_back(v);
  endfunction

  logic cur;
  int   kind, len;
  logic gv, gc;

  initial begin
    reset = 1'b1; q_in = 1'b0; qn_in = 1'b1; clr_cnt = 1'b0;
    prev_rise = 0; prev_fall = 0;
    clear_obs();

    //   rst q qn clr | rise fall trk flt cnt
    add(1, 0, 1, 0,   0, 0, 0, 0, 0); // 0 reset
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 1 INIT -> TRACK after first edge
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 2 q rises before edge 2
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 3
    add(0, 1, 0, 0,   1, 0, 1, 0, 1); // 4 rise pulse, 2 edges after the change
    add(0, 1, 0, 0,   0, 0, 1, 0, 1); // 5 single-cycle pulse
    add(0, 0, 1, 0,   0, 0, 1, 0, 1); // 6 q falls
    add(0, 0, 1, 0,   0, 0, 1, 0, 1); // 7
    add(0, 0, 1, 0,   0, 1, 1, 0, 1); // 8 fall pulse
    add(0, 0, 1, 0,   0, 0, 1, 0, 1); // 9
    add(0, 1, 1, 0,   0, 0, 1, 0, 1); // 10 two-cycle Q==Qn glitch
    add(0, 1, 1, 0,   0, 0, 1, 0, 1); // 11
    add(0, 0, 1, 0,   0, 0, 1, 0, 1); // 12 back to the old value
    add(0, 0, 1, 0,   0, 0, 1, 0, 1); // 13 no fault, no pulse
    add(0, 0, 1, 0,   0, 0, 1, 0, 1); // 14
    add(0, 0, 0, 0,   0, 0, 1, 0, 1); // 15 long invalid run starts
    add(0, 0, 0, 0,   0, 0, 1, 0, 1); // 16
    add(0, 0, 0, 0,   0, 0, 1, 0, 1); // 17 invalid #1 seen
    add(0, 0, 0, 0,   0, 0, 1, 0, 1); // 18 invalid #2
    add(0, 0, 0, 1,   0, 0, 0, 1, 0); // 19 invalid #3: fault, clr clears the count
    add(0, 0, 0, 1,   0, 0, 0, 1, 0); // 20 clr while invalid: fault persists
    add(0, 1, 0, 1,   0, 0, 0, 1, 0); // 21 valid at input, not yet synced
    add(0, 1, 0, 1,   0, 0, 0, 1, 0); // 22
    add(0, 1, 0, 1,   0, 0, 0, 0, 0); // 23 FAULT -> INIT
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 24 INIT -> TRACK, silent
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 25
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 26
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 27
    add(0, 0, 1, 0,   0, 1, 1, 0, 0); // 28 fall pulse
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 29
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 30
    add(0, 1, 0, 1,   1, 0, 1, 0, 0); // 31 clr together with rise: count 0, pulse fires
    add(0, 1, 0, 0,   0, 0, 1, 0, 0); // 32
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 33 toggle
    add(1, 0, 1, 0,   0, 0, 0, 0, 0); // 34 reset one cycle later
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 35 back in TRACK, no pulse
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 36
    add(0, 0, 1, 0,   0, 0, 1, 0, 0); // 37

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].q, vq[i].qn, vq[i].clr);
      chk($sformatf("vec%0d_rise", i), rise8, vq[i].rise);
      chk($sformatf("vec%0d_fall", i), fall8, vq[i].fall);
      chk($sformatf("vec%0d_trk", i),  trk8,  vq[i].trk);
      chk($sformatf("vec%0d_flt", i),  flt8,  vq[i].flt);
      chk($sformatf("vec%0d_cnt8", i), cnt8,  vq[i].cnt);
      chk($sformatf("vec%0d_cnt3", i), cnt3,  vq[i].cnt);
    end

    // Five full periods, each level held for 6 cycles.
    hold(0, 1, 1, 1);
    hold(0, 1, 0, 4);
    clear_obs();
    for (int p = 0; p < 5; p++) begin
      hold(1, 0, 0, 6);
      hold(0, 1, 0, 6);
    end
    chk("periods_rise_count", obs_rise, 5);
    chk("periods_fall_count", obs_fall, 5);
    chk("periods_pulse_width", wide_err, 0);
    chk("periods_cnt8", cnt8, 5);

    // Two-cycle glitch, then return to the same level: nothing happens.
    clear_obs();
    hold(1, 1, 0, 2);
    hold(0, 1, 0, 6);
    chk("glitch_same_pulses", obs_rise + obs_fall, 0);
    chk("glitch_same_fault", flt8, 0);
    chk("glitch_same_cnt8", cnt8, 5);

    // Two-cycle glitch, then return to the opposite level: exactly one rise.
    hold(1, 1, 0, 2);
    hold(1, 0, 0, 6);
    chk("glitch_opp_rise", obs_rise, 1);
    chk("glitch_opp_fall", obs_fall, 0);
    chk("glitch_opp_fault", flt8, 0);
    chk("glitch_opp_cnt8", cnt8, 6);

    // Saturation: 9 rising edges into a 3-bit counter.
    hold(0, 1, 1, 1);
    hold(0, 1, 0, 4);
    clear_obs();
    for (int p = 0; p < 9; p++) begin
      hold(1, 0, 0, 3);
      hold(0, 1, 0, 3);
    end
    hold(0, 1, 0, 3);
    chk("sat_rise_count", obs_rise, 9);
    chk("sat_cnt3", cnt3, 7);
    chk("sat_cnt8", cnt8, 9);
    chk("sat_pulse_width", wide_err, 0);

    // Random phase: toggles, glitches of varying length, clears and resets.
    cur = 1'b0;
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 19);
      gc   = ($urandom_range(0, 5) == 0);
      if (kind == 0) begin
        step(1'b1, cur, ~cur, 1'b0);
      end else if (kind <= 4) begin
        len = $urandom_range(1, 5);
        gv  = $urandom_range(0, 1);
        hold(gv, gv, gc, len);
      end else begin
        cur = $urandom_range(0, 1);
        hold(cur, ~cur, gc, $urandom_range(1, 5));
      end
    end
    hold(cur, ~cur, 1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
